instruction_fetch: RTL
======================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter: RESET_VECTOR, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 stall  input  1  downstream hazard hold; current instruction not consumed this cycle.
REQ-005 jump  input  1  redirect request from control unit.
REQ-006 pcLoadImmediate  input  1  redirect source select: 1 = immediateVal, 0 = regTarget.
REQ-007 immediateVal  input  32  immediate/branch target from control unit.
REQ-008 regTarget  input  32  register-file read of src1 (ret target).
REQ-009 imem_req  output  1  instruction memory request.
REQ-010 imem_addr  output  32  word address of request.
REQ-011 imem_ack  input  1  memory response valid; counted only while imem_req=1.
REQ-012 imem_rdata  input  32  instruction word, valid with imem_ack.
REQ-013 instruction  output  32  registered instruction to control unit.
REQ-014 instructionAddress  output  32  registered word address of instruction.
REQ-015 instr_valid  output  1  instruction/instructionAddress hold a live instruction.
REQ-016 linkAddress  output  32  instructionAddress+1, for jal/spc writeback.

Function
REQ-017 PC is word-addressed; sequential increment +1, modulo 2^32 (0xFFFF_FFFF -> 0x0000_0000).
REQ-018 States: START, FETCH, DRAIN.
REQ-019 START: one cycle after reset release, imem_req=0; unconditional transition to FETCH.
REQ-020 FETCH: imem_req = !(instr_valid && stall); imem_addr = pc.
REQ-021 imem_addr and imem_req SHALL stay stable from assertion until the ack cycle, except when stall rises before any ack (req may drop; addr unchanged).
REQ-022 Consume event = instr_valid && !stall.
REQ-023 Ack in FETCH, no redirect: instruction<=imem_rdata, instructionAddress<=pc, instr_valid<=1, pc<=pc+1 next edge; ack same cycle as req is legal (zero-wait memory gives one instruction per cycle).
REQ-024 Consume with no ack: instr_valid<=0, instruction<=0 (nop encoding).
REQ-025 stall with instr_valid=1: instruction, instructionAddress, instr_valid, pc held unchanged.
REQ-026 Redirect event = jump && consume event; target = pcLoadImmediate ? immediateVal : regTarget.
REQ-027 Redirect: pc<=target, instr_valid<=0, instruction<=0 next edge; ack data in same cycle discarded.
REQ-028 Redirect while request pending (req=1, no ack this cycle): go DRAIN; hold imem_addr; on ack discard data, go FETCH at target.
REQ-029 DRAIN: imem_req=1, outputs stay invalid; further redirects ignored (instr_valid=0).
REQ-030 jump while instr_valid=0 or stall=1 SHALL be ignored.
REQ-031 Redirect-to-first-target-instruction latency with zero-wait memory: 2 cycles (redirect edge, fetch edge).
REQ-032 linkAddress = instructionAddress+1 combinational, modulo 2^32.

Reset
REQ-033 rst_n=0 at edge: state<=START, pc<=RESET_VECTOR, instruction<=0, instructionAddress<=0, instr_valid<=0; imem_req=0 while rst_n=0.
REQ-034 Reset mid-request abandons outstanding request; acks during reset and in START SHALL be ignored.

Verification
REQ-035 Reset, zero-wait memory returning addr as data -> instructionAddress 0,1,2,3 on consecutive cycles, instruction equals address, instr_valid=1 from cycle 3 after release.
REQ-036 stall high 3 cycles at instructionAddress=5 -> outputs hold 5, imem_req=0, imem_addr=6 held; release -> 6 next cycle.
REQ-037 jump=1, pcLoadImmediate=1, immediateVal=0x40 at address 2 -> instr_valid=0 next cycle, then instructionAddress=0x40; data for address 3 never presented.
REQ-038 Memory with 3-cycle ack; jump (pcLoadImmediate=0, regTarget=0x10) while request for address 7 pending -> DRAIN, address-7 data discarded, next valid instructionAddress=0x10.
REQ-039 pc=0xFFFF_FFFF fetched -> linkAddress=0, next instructionAddress=0.
REQ-040 rst_n low one cycle during pending request -> all outputs reset values, next fetch at RESET_VECTOR, stale ack ignored.

Source files
------------

// File: rtl/instruction_fetch.sv
// ============================================================================
// Module   : instruction_fetch
// Purpose  : Word-addressed instruction fetch with stall hold, jump redirect
//            and drain of an in-flight request after a redirect.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        jump,
    input  logic        pcLoadImmediate,
    input  logic [31:0] immediateVal,
    input  logic [31:0] regTarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] instructionAddress,
    output logic        instr_valid,
    output logic [31:0] linkAddress
);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [31:0] C_NOP = 32'h0000_0000;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] target_q, target_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] iaddr_q, iaddr_d;
    logic        valid_q, valid_d;

    logic        w_req;
    logic        w_ack;
    logic        w_consume;
    logic        w_redirect;
    logic [31:0] w_target;

    assign w_consume  = valid_q && !stall;
    assign w_redirect = jump && w_consume;
    assign w_target   = pcLoadImmediate ? immediateVal : regTarget;
    assign w_ack      = w_req && imem_ack;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        target_d = target_q;
        instr_d  = instr_q;
        iaddr_d  = iaddr_q;
        valid_d  = valid_q;
        w_req    = 1'b0;

        case (state_q)
            ST_START: begin
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                w_req = !(valid_q && stall);
                if (w_redirect) begin
                    valid_d = 1'b0;
                    instr_d = C_NOP;
                    // An un-acked request must complete on the bus before
                    // the address may move, so park the target until then.
                    if (w_ack) begin
                        pc_d = w_target;
                    end else begin
                        target_d = w_target;
                        state_d  = ST_DRAIN;
                    end
                end else if (w_ack) begin
                    instr_d = imem_rdata;
                    iaddr_d = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 32'd1;
                end else if (w_consume) begin
                    valid_d = 1'b0;
                    instr_d = C_NOP;
                end
            end

            ST_DRAIN: begin
                w_req = 1'b1;
                if (imem_ack) begin
                    pc_d    = target_q;
                    state_d = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_START;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_START;
            pc_q     <= RESET_VECTOR;
            target_q <= RESET_VECTOR;
            instr_q  <= C_NOP;
            iaddr_q  <= 32'h0000_0000;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            instr_q  <= instr_d;
            iaddr_q  <= iaddr_d;
            valid_q  <= valid_d;
        end
    end

    assign imem_req           = rst_n && w_req;
    assign imem_addr          = pc_q;
    assign instruction        = instr_q;
    assign instructionAddress = iaddr_q;
    assign instr_valid        = valid_q;
    assign linkAddress        = iaddr_q + 32'd1;

endmodule

`default_nettype wire
